// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window assembler fed by line-buffer column taps.
// Tracks raster position, suppresses border windows and applies the conv stride.
module window_3x3_gen #(
  parameter int DATA_W = 16,
  parameter int WIDTH  = 416,
  parameter int HEIGHT = 416,
  parameter int STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         tap_top,
  input  logic [DATA_W-1:0]         tap_mid,
  input  logic [DATA_W-1:0]         tap_bot,
  input  logic                      tap_valid,
  output logic [9*DATA_W-1:0]       win_data,
  output logic                      win_valid,
  output logic [$clog2(HEIGHT)-1:0] win_row,
  output logic [$clog2(WIDTH)-1:0]  win_col,
  output logic                      frame_done
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic          STRIDE2  = (STRIDE == 2);

  generate
    if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
      $error("window_3x3_gen: STRIDE must be 1 or 2");
    end
  endgenerate

  // Column words pack the three rows as [i*DATA_W +: DATA_W], i=0 top.
  logic [3*DATA_W-1:0] c0, c1, taps;
  logic [9*DATA_W-1:0] win_next;
  logic [CW-1:0]       col_cnt;
  logic [RW-1:0]       row_cnt;
  logic                col_ph, row_ph;
  logic                col_wrap, row_wrap, emit;

  assign taps     = {tap_bot, tap_mid, tap_top};
  assign col_wrap = (col_cnt == COL_LAST);
  assign row_wrap = (row_cnt == ROW_LAST);
  // Phase bits track position parity; with stride 2, (n-2)%2 == n%2.
  assign emit     = (col_cnt >= CW'(2)) && (row_cnt >= RW'(2)) && !col_ph && !row_ph;

  always_comb begin
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      win_next[(3*i+0)*DATA_W +: DATA_W] = c0[i*DATA_W +: DATA_W];
      win_next[(3*i+1)*DATA_W +: DATA_W] = c1[i*DATA_W +: DATA_W];
      win_next[(3*i+2)*DATA_W +: DATA_W] = taps[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0         <= '0;
      c1         <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      col_ph     <= 1'b0;
      row_ph     <= 1'b0;
      win_data   <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (tap_valid) begin
        c0 <= c1;
        c1 <= taps;
        if (col_wrap) begin
          col_cnt <= '0;
          col_ph  <= 1'b0;
          if (row_wrap) begin
            row_cnt <= '0;
            row_ph  <= 1'b0;
          end else begin
            row_cnt <= row_cnt + RW'(1);
            row_ph  <= STRIDE2 & ~row_ph;
          end
        end else begin
          col_cnt <= col_cnt + CW'(1);
          col_ph  <= STRIDE2 & ~col_ph;
        end
        if (emit) begin
          win_valid <= 1'b1;
          win_data  <= win_next;
          win_row   <= row_cnt - RW'(2);
          win_col   <= col_cnt - CW'(2);
        end
        frame_done <= col_wrap && row_wrap;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen: three instances (5x4 s1, 6x6 s2, 416x16 s1)
// compared against a software 3x3 extraction of the driven image.
module tb_window_3x3_gen;

  localparam int AW = 5,   AH = 4;
  localparam int BW = 6,   BH = 6;
  localparam int XW = 416, XH = 16;

  typedef struct packed {
    logic [15:0]  row;
    logic [15:0]  col;
    logic [143:0] data;
    logic [31:0]  tap;
  } win_t;

  logic clk, rst;
  int   n_cmp, n_bad;

  logic [15:0] a_top, a_mid, a_bot, b_top, b_mid, b_bot, c_top, c_mid, c_bot;
  logic        a_valid, b_valid, c_valid;
  logic [143:0] a_data, b_data, c_data;
  logic        a_wv, b_wv, c_wv, a_fd, b_fd, c_fd;
  logic [1:0]  a_row;
  logic [2:0]  a_col, b_row, b_col;
  logic [3:0]  c_row;
  logic [8:0]  c_col;

  window_3x3_gen #(.DATA_W(16), .WIDTH(AW), .HEIGHT(AH), .STRIDE(1)) u_a (
    .clk(clk), .rst(rst), .tap_top(a_top), .tap_mid(a_mid), .tap_bot(a_bot),
    .tap_valid(a_valid), .win_data(a_data), .win_valid(a_wv), .win_row(a_row),
    .win_col(a_col), .frame_done(a_fd));

  window_3x3_gen #(.DATA_W(16), .WIDTH(BW), .HEIGHT(BH), .STRIDE(2)) u_b (
    .clk(clk), .rst(rst), .tap_top(b_top), .tap_mid(b_mid), .tap_bot(b_bot),
    .tap_valid(b_valid), .win_data(b_data), .win_valid(b_wv), .win_row(b_row),
    .win_col(b_col), .frame_done(b_fd));

  window_3x3_gen #(.DATA_W(16), .WIDTH(XW), .HEIGHT(XH), .STRIDE(1)) u_c (
    .clk(clk), .rst(rst), .tap_top(c_top), .tap_mid(c_mid), .tap_bot(c_bot),
    .tap_valid(c_valid), .win_data(c_data), .win_valid(c_wv), .win_row(c_row),
    .win_col(c_col), .frame_done(c_fd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] img_a [0:AH-1][0:AW-1];
  logic [15:0] img_b [0:BH-1][0:BW-1];
  logic [15:0] img_c [0:XH-1][0:XW-1];

  win_t exp_a[$], obs_a[$], exp_b[$], obs_b[$], exp_c[$], obs_c[$];
  int   exp_fd_a[$], fd_a[$], exp_fd_b[$], fd_b[$], exp_fd_c[$], fd_c[$];
  int   a_taps, b_taps, c_taps, a_plan, b_plan, c_plan;
  int   a_idle_hi, a_idle_chg;

  // Observers: record windows and frame_done pulses tagged with the running tap count.
  logic a_vs, a_rs, b_vs, b_rs, c_vs, c_rs;
  logic [143:0] a_pd;
  logic [1:0]   a_pr;
  logic [2:0]   a_pc;
  win_t a_w, b_w, c_w;

  always @(posedge clk) begin
    a_vs = a_valid; a_rs = rst;
    #1;
    if (!a_rs) begin
      if (a_vs) a_taps++;
      if (a_wv) begin
        a_w.row = 16'(a_row); a_w.col = 16'(a_col); a_w.data = a_data; a_w.tap = 32'(a_taps);
        obs_a.push_back(a_w);
      end
      if (a_fd) fd_a.push_back(a_taps);
      if (!a_vs && (a_wv || a_fd)) a_idle_hi++;
      if (!a_vs && (a_data !== a_pd || a_row !== a_pr || a_col !== a_pc)) a_idle_chg++;
    end
    a_pd = a_data; a_pr = a_row; a_pc = a_col;
  end

  always @(posedge clk) begin
    b_vs = b_valid; b_rs = rst;
    #1;
    if (!b_rs) begin
      if (b_vs) b_taps++;
      if (b_wv) begin
        b_w.row = 16'(b_row); b_w.col = 16'(b_col); b_w.data = b_data; b_w.tap = 32'(b_taps);
        obs_b.push_back(b_w);
      end
      if (b_fd) fd_b.push_back(b_taps);
    end
  end

  always @(posedge clk) begin
    c_vs = c_valid; c_rs = rst;
    #1;
    if (!c_rs) begin
      if (c_vs) c_taps++;
      if (c_wv) begin
        c_w.row = 16'(c_row); c_w.col = 16'(c_col); c_w.data = c_data; c_w.tap = 32'(c_taps);
        obs_c.push_back(c_w);
      end
      if (c_fd) fd_c.push_back(c_taps);
    end
  end

  // Reference: fill an image, then list every valid-conv window position in raster order.
  task automatic gen_a(input bit ramp);
    win_t w;
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) img_a[r][c] = ramp ? 16'(16*r + c) : 16'($urandom);
    for (int r0 = 0; r0 + 3 <= AH; r0 += 1)
      for (int c0 = 0; c0 + 3 <= AW; c0 += 1) begin
        w.row = 16'(r0); w.col = 16'(c0); w.tap = 32'(a_plan + (r0+2)*AW + c0 + 3);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) w.data[(3*i+j)*16 +: 16] = img_a[r0+i][c0+j];
        exp_a.push_back(w);
      end
    a_plan += AW*AH;
    exp_fd_a.push_back(a_plan);
  endtask

  task automatic gen_b();
    win_t w;
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) img_b[r][c] = 16'(16*r + c);
    for (int r0 = 0; r0 + 3 <= BH; r0 += 2)
      for (int c0 = 0; c0 + 3 <= BW; c0 += 2) begin
        w.row = 16'(r0); w.col = 16'(c0); w.tap = 32'(b_plan + (r0+2)*BW + c0 + 3);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) w.data[(3*i+j)*16 +: 16] = img_b[r0+i][c0+j];
        exp_b.push_back(w);
      end
    b_plan += BW*BH;
    exp_fd_b.push_back(b_plan);
  endtask

  task automatic gen_c();
    win_t w;
    for (int r = 0; r < XH; r++)
      for (int c = 0; c < XW; c++) img_c[r][c] = 16'($urandom);
    for (int r0 = 0; r0 + 3 <= XH; r0++)
      for (int c0 = 0; c0 + 3 <= XW; c0++) begin
        w.row = 16'(r0); w.col = 16'(c0); w.tap = 32'(c_plan + (r0+2)*XW + c0 + 3);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) w.data[(3*i+j)*16 +: 16] = img_c[r0+i][c0+j];
        exp_c.push_back(w);
      end
    c_plan += XW*XH;
    exp_fd_c.push_back(c_plan);
  endtask

  // Drivers emulate the line buffer; rows above the frame carry random stale data.
  task automatic play_a(input bit gap, input int ntaps);
    int n;
    n = 0;
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        if (n == ntaps) return;
        if (gap) begin
          for (int k = 0; k < 8 && $urandom_range(0, 99) < 60; k++) begin
            a_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        a_top = 16'($urandom); a_mid = 16'($urandom);
        if (r >= 2) a_top = img_a[r-2][c];
        if (r >= 1) a_mid = img_a[r-1][c];
        a_bot = img_a[r][c];
        a_valid = 1'b1;
        @(posedge clk); #1;
        n++;
      end
  endtask

  task automatic play_b();
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) begin
        b_top = 16'($urandom); b_mid = 16'($urandom);
        if (r >= 2) b_top = img_b[r-2][c];
        if (r >= 1) b_mid = img_b[r-1][c];
        b_bot = img_b[r][c];
        b_valid = 1'b1;
        @(posedge clk); #1;
      end
  endtask

  task automatic play_c();
    for (int r = 0; r < XH; r++)
      for (int c = 0; c < XW; c++) begin
        c_top = 16'($urandom); c_mid = 16'($urandom);
        if (r >= 2) c_top = img_c[r-2][c];
        if (r >= 1) c_mid = img_c[r-1][c];
        c_bot = img_c[r][c];
        c_valid = 1'b1;
        @(posedge clk); #1;
      end
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_a();
    exp_a.delete(); obs_a.delete(); exp_fd_a.delete(); fd_a.delete();
    a_taps = 0; a_plan = 0; a_idle_hi = 0; a_idle_chg = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_cmp++;
    if ({a_data, a_wv, a_row, a_col, a_fd} !== '0) begin
      n_bad++; $display("FAIL reset_a got data=%h v=%b r=%0d c=%0d fd=%b want all 0", a_data, a_wv, a_row, a_col, a_fd);
    end
    n_cmp++;
    if ({b_data, b_wv, b_row, b_col, b_fd, c_data, c_wv, c_row, c_col, c_fd} !== '0) begin
      n_bad++; $display("FAIL reset_bc got b_v=%b c_v=%b b_data=%h want all 0", b_wv, c_wv, b_data);
    end
    rst = 1'b0;
    clr_a();
  endtask

  task automatic test_ramp();
    clr_a();
    gen_a(1'b1);
    play_a(1'b0, AW*AH);
    idle(3);
    n_cmp++;
    if (obs_a.size() != 6) begin n_bad++; $display("FAIL ramp_count got %0d want 6", obs_a.size()); end
    if (obs_a.size() >= 1) begin
      n_cmp++;
      if (obs_a[0].row != 0 || obs_a[0].col != 0 || obs_a[0].tap != 13 || obs_a[0].data[15:0] != 16'h00 ||
          obs_a[0].data[79:64] != 16'h11 || obs_a[0].data[143:128] != 16'h22) begin
        n_bad++; $display("FAIL ramp_first got (%0d,%0d) tap %0d data %h want (0,0) tap 13 e00=00 e11=11 e22=22",
                          obs_a[0].row, obs_a[0].col, obs_a[0].tap, obs_a[0].data);
      end
      n_cmp++;
      if (obs_a[obs_a.size()-1].row != 1 || obs_a[obs_a.size()-1].col != 2) begin
        n_bad++; $display("FAIL ramp_last got (%0d,%0d) want (1,2)", obs_a[obs_a.size()-1].row, obs_a[obs_a.size()-1].col);
      end
    end
    for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
      n_cmp++;
      if (obs_a[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL ramp_win%0d got (%0d,%0d) tap %0d %h want (%0d,%0d) tap %0d %h", k, obs_a[k].row,
                          obs_a[k].col, obs_a[k].tap, obs_a[k].data, exp_a[k].row, exp_a[k].col, exp_a[k].tap, exp_a[k].data);
      end
    end
    n_cmp++;
    if (fd_a != exp_fd_a) begin n_bad++; $display("FAIL ramp_frame_done got %0d pulses want 1 at tap 20", fd_a.size()); end
  endtask

  task automatic test_stride2();
    gen_b();
    play_b();
    idle(3);
    n_cmp++;
    if (obs_b.size() != 4) begin n_bad++; $display("FAIL s2_count got %0d want 4", obs_b.size()); end
    for (int k = 0; k < exp_b.size() && k < obs_b.size(); k++) begin
      n_cmp++;
      if (obs_b[k] !== exp_b[k]) begin
        n_bad++; $display("FAIL s2_win%0d got (%0d,%0d) tap %0d %h want (%0d,%0d) tap %0d %h", k, obs_b[k].row,
                          obs_b[k].col, obs_b[k].tap, obs_b[k].data, exp_b[k].row, exp_b[k].col, exp_b[k].tap, exp_b[k].data);
      end
    end
    for (int k = 0; k < obs_b.size(); k++) begin
      n_cmp++;
      if (obs_b[k].row[0] || obs_b[k].col[0]) begin
        n_bad++; $display("FAIL s2_odd got (%0d,%0d) want even coords", obs_b[k].row, obs_b[k].col);
      end
    end
    n_cmp++;
    if (fd_b != exp_fd_b) begin n_bad++; $display("FAIL s2_frame_done got %0d pulses want 1 at tap 36", fd_b.size()); end
  endtask

  task automatic test_gapped();
    clr_a();
    gen_a(1'b0);
    play_a(1'b1, AW*AH);
    idle(3);
    n_cmp++;
    if (obs_a.size() != exp_a.size()) begin n_bad++; $display("FAIL gap_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
      n_cmp++;
      if (obs_a[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL gap_win%0d got (%0d,%0d) tap %0d %h want (%0d,%0d) tap %0d %h", k, obs_a[k].row,
                          obs_a[k].col, obs_a[k].tap, obs_a[k].data, exp_a[k].row, exp_a[k].col, exp_a[k].tap, exp_a[k].data);
      end
    end
    n_cmp++;
    if (a_idle_hi != 0) begin n_bad++; $display("FAIL gap_idle_valid got %0d pulses after idle want 0", a_idle_hi); end
    n_cmp++;
    if (a_idle_chg != 0) begin n_bad++; $display("FAIL gap_idle_hold got %0d output changes while idle want 0", a_idle_chg); end
    n_cmp++;
    if (fd_a != exp_fd_a) begin n_bad++; $display("FAIL gap_frame_done got %0d pulses want 1", fd_a.size()); end
  endtask

  task automatic test_back_to_back();
    clr_a();
    gen_a(1'b0);
    play_a(1'b0, AW*AH);
    gen_a(1'b0);
    play_a(1'b0, AW*AH);
    idle(3);
    n_cmp++;
    if (obs_a.size() != 12) begin n_bad++; $display("FAIL b2b_count got %0d want 12", obs_a.size()); end
    for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
      n_cmp++;
      if (obs_a[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL b2b_win%0d got (%0d,%0d) tap %0d %h want (%0d,%0d) tap %0d %h", k, obs_a[k].row,
                          obs_a[k].col, obs_a[k].tap, obs_a[k].data, exp_a[k].row, exp_a[k].col, exp_a[k].tap, exp_a[k].data);
      end
    end
    n_cmp++;
    if (fd_a.size() != 2 || fd_a[0] != 20 || fd_a[1] != 40) begin
      n_bad++; $display("FAIL b2b_frame_done got %0d pulses want 2 at taps 20,40", fd_a.size());
    end
  endtask

  task automatic test_reset_mid();
    clr_a();
    gen_a(1'b1);
    play_a(1'b0, 2*AW + 4);
    rst = 1'b1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs_a.size() != 2) begin n_bad++; $display("FAIL rstmid_pre got %0d windows want 2", obs_a.size()); end
    n_cmp++;
    if ({a_data, a_wv, a_row, a_col, a_fd} !== '0) begin
      n_bad++; $display("FAIL rstmid_zero got data=%h v=%b r=%0d c=%0d fd=%b want all 0", a_data, a_wv, a_row, a_col, a_fd);
    end
    rst = 1'b0;
    clr_a();
    gen_a(1'b0);
    play_a(1'b0, AW*AH);
    idle(3);
    n_cmp++;
    if (obs_a.size() != 6) begin n_bad++; $display("FAIL rstmid_count got %0d want 6", obs_a.size()); end
    for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
      n_cmp++;
      if (obs_a[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL rstmid_win%0d got (%0d,%0d) tap %0d %h want (%0d,%0d) tap %0d %h", k, obs_a[k].row,
                          obs_a[k].col, obs_a[k].tap, obs_a[k].data, exp_a[k].row, exp_a[k].col, exp_a[k].tap, exp_a[k].data);
      end
    end
    n_cmp++;
    if (fd_a != exp_fd_a) begin n_bad++; $display("FAIL rstmid_frame_done got %0d pulses want 1 at tap 20", fd_a.size()); end
  endtask

  task automatic test_wide();
    int errs;
    errs = 0;
    gen_c();
    play_c();
    idle(3);
    n_cmp++;
    if (obs_c.size() != (XW-2)*(XH-2)) begin
      n_bad++; $display("FAIL wide_count got %0d want %0d", obs_c.size(), (XW-2)*(XH-2));
    end
    for (int k = 0; k < exp_c.size() && k < obs_c.size(); k++) begin
      n_cmp++;
      if (obs_c[k] !== exp_c[k]) begin
        n_bad++;
        if (errs < 10) $display("FAIL wide_win%0d got (%0d,%0d) tap %0d %h want (%0d,%0d) tap %0d %h", k, obs_c[k].row,
                                obs_c[k].col, obs_c[k].tap, obs_c[k].data, exp_c[k].row, exp_c[k].col, exp_c[k].tap, exp_c[k].data);
        errs++;
      end
    end
    n_cmp++;
    if (fd_c != exp_fd_c) begin n_bad++; $display("FAIL wide_frame_done got %0d pulses want 1 at tap %0d", fd_c.size(), XW*XH); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    a_top = '0; a_mid = '0; a_bot = '0; a_valid = 1'b0;
    b_top = '0; b_mid = '0; b_bot = '0; b_valid = 1'b0;
    c_top = '0; c_mid = '0; c_bot = '0; c_valid = 1'b0;
    a_taps = 0; b_taps = 0; c_taps = 0; a_plan = 0; b_plan = 0; c_plan = 0;
    a_idle_hi = 0; a_idle_chg = 0;
    rst = 1'b1;
    test_reset();
    test_ramp();
    test_stride2();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
